// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//  Shares one single-ported memory between the instruction-fetch requester (I) and the
//  load/store requester (D). Arbitrates round-robin on ties, drives a registered memory
//  address/wdata/wr, waits out the fixed memory latency and returns read data with a
//  one-cycle done pulse to the winner.
// Ports
//  Clk, Reset                  clock and synchronous active-high reset
//  I_req/I_addr                fetch read request (held until I_done)
//  I_rdata/I_done              fetch read data (held) and completion pulse
//  D_req/D_wr/D_addr/D_wdata   load/store request (held until D_done)
//  D_rdata/D_done              load data (held) and completion pulse
//  Mem_addr/Mem_wdata/Mem_wr   registered memory command
//  Mem_rdata                   memory read data
//  Busy/StateOut               debug status (IDLE=0, ACCESS=1, RESP=2)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [DATA_W-1:0] I_rdata,
    output logic              I_done,
    input  logic              D_req,
    input  logic              D_wr,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_done,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    output logic              Mem_wr,
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic              Busy,
    output logic [1:0]        StateOut
);

    localparam int unsigned CNT_W   = 4;
    localparam logic        GRANT_I = 1'b0;
    localparam logic        GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;
    logic                win_d_c;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (I_req || D_req) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // D wins when it is the only requester, or on a tie when I was granted last
    assign win_d_c = D_req && (!I_req || (last_grant_q == GRANT_I));

    // Datapath / output next values
    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_d     = mem_wr_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (I_req || D_req) begin
                    last_grant_d = win_d_c ? GRANT_D : GRANT_I;
                    mem_addr_d   = win_d_c ? D_addr : I_addr;
                    if (win_d_c) mem_wdata_d = D_wdata;
                    mem_wr_d     = win_d_c && D_wr;
                    cnt_d        = (win_d_c && D_wr) ? CNT_W'(WRITE_LATENCY - 1)
                                                     : CNT_W'(READ_LATENCY - 1);
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Mem_wr still reflects the access type until this edge
                    if (!mem_wr_q) begin
                        if (last_grant_q == GRANT_D) d_rdata_d = Mem_rdata;
                        else                         i_rdata_d = Mem_rdata;
                    end
                    mem_wr_d = 1'b0;
                    if (last_grant_q == GRANT_D) d_done_d = 1'b1;
                    else                         i_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q        <= '0;
            last_grant_q <= GRANT_D;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_q     <= mem_wr_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
        end
    end

    // Output mapping (all from flops)
    always_comb begin
        Mem_addr  = mem_addr_q;
        Mem_wdata = mem_wdata_q;
        Mem_wr    = mem_wr_q;
        I_rdata   = i_rdata_q;
        D_rdata   = d_rdata_q;
        I_done    = i_done_q;
        D_done    = d_done_q;
        Busy      = (state_q != IDLE);
        StateOut  = state_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a READ_LATENCY=2/WRITE_LATENCY=1 instance for the
// main sequence and a READ_LATENCY=1/WRITE_LATENCY=3 instance for back-to-back timing.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          I_req, D_req, D_wr;
    logic [AW-1:0] I_addr, D_addr;
    logic [DW-1:0] D_wdata, mem_rdata;
    logic [DW-1:0] I_rdata, D_rdata, Mem_wdata;
    logic [AW-1:0] Mem_addr;
    logic          I_done, D_done, Mem_wr, Busy;
    logic [1:0]    StateOut;

    logic          u1_I_req, u1_D_req, u1_D_wr;
    logic [AW-1:0] u1_I_addr, u1_D_addr, u1_Mem_addr;
    logic [DW-1:0] u1_D_wdata, u1_mem_rdata, u1_I_rdata, u1_D_rdata, u1_Mem_wdata;
    logic          u1_I_done, u1_D_done, u1_Mem_wr, u1_Busy;
    logic [1:0]    u1_StateOut;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut (
        .Clk(clk), .Reset(reset),
        .I_req(I_req), .I_addr(I_addr), .I_rdata(I_rdata), .I_done(I_done),
        .D_req(D_req), .D_wr(D_wr), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_done(D_done),
        .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata), .Mem_wr(Mem_wr), .Mem_rdata(mem_rdata),
        .Busy(Busy), .StateOut(StateOut)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .WRITE_LATENCY(3)) u1 (
        .Clk(clk), .Reset(reset),
        .I_req(u1_I_req), .I_addr(u1_I_addr), .I_rdata(u1_I_rdata), .I_done(u1_I_done),
        .D_req(u1_D_req), .D_wr(u1_D_wr), .D_addr(u1_D_addr), .D_wdata(u1_D_wdata),
        .D_rdata(u1_D_rdata), .D_done(u1_D_done),
        .Mem_addr(u1_Mem_addr), .Mem_wdata(u1_Mem_wdata), .Mem_wr(u1_Mem_wr),
        .Mem_rdata(u1_mem_rdata), .Busy(u1_Busy), .StateOut(u1_StateOut)
    );

    // Expected completion: port code {I_done,D_done}, winner rdata, edges since reference (0 = unchecked)
    typedef struct {
        logic [1:0]  port;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance edge by edge until a done pulse on the main instance, bounded
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(I_done || D_done) && cyc < 40);
        chk({tag, "_done_seen"}, 64'(I_done || D_done), 64'd1);
    endtask

    task automatic check_pop(input string tag, input int cyc);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_port"}, 64'({I_done, D_done}), 64'(e.port));
            chk({tag, "_rdata"}, 64'((e.port == 2'b10) ? I_rdata : D_rdata), 64'(e.data));
            if (e.lat != 0) chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
        end
    endtask

    task automatic idle_gap(input string tag);
        @(posedge clk); #1;
        chk({tag, "_idle_state"}, 64'(StateOut), 64'd0);
        chk({tag, "_idle_busy"}, 64'(Busy), 64'd0);
    endtask

    // Protocol invariants on both instances every cycle
    always @(negedge clk) begin
        chk("excl_done", 64'(I_done && D_done), 64'd0);
        chk("wr_outside_access", 64'(Mem_wr && (StateOut != 2'd1)), 64'd0);
        chk("u1_wr_outside_access", 64'(u1_Mem_wr && (u1_StateOut != 2'd1)), 64'd0);
    end

    initial begin
        int          cyc;
        int          n;
        int          wr_cycles;
        logic [31:0] tbl [4];
        logic        busy_pat [3];
        logic        done_pat [3];

        reset = 1'b1;
        I_req = 1'b0; D_req = 1'b0; D_wr = 1'b0;
        I_addr = '0; D_addr = '0; D_wdata = '0; mem_rdata = '0;
        u1_I_req = 1'b0; u1_D_req = 1'b0; u1_D_wr = 1'b0;
        u1_I_addr = '0; u1_D_addr = '0; u1_D_wdata = '0; u1_mem_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(StateOut), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_mem_addr", 64'(Mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(Mem_wdata), 64'd0);
        chk("rst_mem_wr", 64'(Mem_wr), 64'd0);
        chk("rst_dones", 64'({I_done, D_done}), 64'd0);
        chk("rst_i_rdata", 64'(I_rdata), 64'd0);
        chk("rst_d_rdata", 64'(D_rdata), 64'd0);
        reset = 1'b0;

        // T1: single fetch read
        mem_rdata = 32'hDEADBEEF; I_addr = 32'h4; I_req = 1'b1;
        sb.push_back('{2'b10, 32'hDEADBEEF, 2});
        @(posedge clk); #1;
        chk("t1_state_access", 64'(StateOut), 64'd1);
        chk("t1_mem_addr", 64'(Mem_addr), 64'h4);
        chk("t1_mem_wr", 64'(Mem_wr), 64'd0);
        chk("t1_busy", 64'(Busy), 64'd1);
        wait_done("t1", cyc);
        check_pop("t1", cyc);
        I_req = 1'b0;
        idle_gap("t1");

        // D read to give D_rdata a known non-zero value
        mem_rdata = 32'hCAFEF00D; D_addr = 32'h80; D_wr = 1'b0; D_req = 1'b1;
        sb.push_back('{2'b01, 32'hCAFEF00D, 2});
        @(posedge clk); #1;
        chk("drd_mem_addr", 64'(Mem_addr), 64'h80);
        wait_done("drd", cyc);
        check_pop("drd", cyc);
        D_req = 1'b0;
        idle_gap("drd");

        // T2: D write, one-cycle strobe, D_rdata untouched
        D_wr = 1'b1; D_addr = 32'h40; D_wdata = 32'h12345678; D_req = 1'b1;
        sb.push_back('{2'b01, 32'hCAFEF00D, 1});
        @(posedge clk); #1;
        chk("t2_mem_wr_hi", 64'(Mem_wr), 64'd1);
        chk("t2_mem_addr", 64'(Mem_addr), 64'h40);
        chk("t2_mem_wdata", 64'(Mem_wdata), 64'h12345678);
        wait_done("t2", cyc);
        check_pop("t2", cyc);
        chk("t2_mem_wr_lo", 64'(Mem_wr), 64'd0);
        chk("t2_i_rdata_kept", 64'(I_rdata), 64'hDEADBEEF);
        D_req = 1'b0; D_wr = 1'b0;
        idle_gap("t2");

        // T6: memory data moves on; captured values hold until the next read of that port
        mem_rdata = 32'h55AA55AA;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_i_hold", 64'(I_rdata), 64'hDEADBEEF);
        chk("t6_d_hold", 64'(D_rdata), 64'hCAFEF00D);
        I_addr = 32'h8; I_req = 1'b1;
        sb.push_back('{2'b10, 32'h55AA55AA, 2});
        @(posedge clk); #1;
        wait_done("t6", cyc);
        check_pop("t6", cyc);
        chk("t6_d_still_hold", 64'(D_rdata), 64'hCAFEF00D);
        I_req = 1'b0;
        idle_gap("t6");

        // T3: both requesters held from reset -> I,D,I,D spaced LAT+2 apart
        reset = 1'b1;
        I_req = 1'b1; D_req = 1'b1; D_wr = 1'b0;
        I_addr = 32'h200; D_addr = 32'h100;
        tbl[0] = 32'hA1A1A1A1; tbl[1] = 32'hB2B2B2B2;
        tbl[2] = 32'hC3C3C3C3; tbl[3] = 32'hD4D4D4D4;
        sb.push_back('{2'b10, tbl[0], 0});
        sb.push_back('{2'b01, tbl[1], 4});
        sb.push_back('{2'b10, tbl[2], 4});
        sb.push_back('{2'b01, tbl[3], 4});
        mem_rdata = tbl[0];
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_done("t3", cyc);
            check_pop("t3", cyc);
            if (i < 3) mem_rdata = tbl[i+1];
        end
        I_req = 1'b0; D_req = 1'b0;
        idle_gap("t3");

        // T4: reset during a D write access, then the held request completes
        D_wr = 1'b1; D_addr = 32'h44; D_wdata = 32'hA5A50001; D_req = 1'b1;
        @(posedge clk); #1;
        chk("t4_wr_started", 64'(Mem_wr), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t4_rst_mem_wr", 64'(Mem_wr), 64'd0);
        chk("t4_rst_state", 64'(StateOut), 64'd0);
        chk("t4_rst_no_done", 64'(D_done), 64'd0);
        chk("t4_rst_d_rdata", 64'(D_rdata), 64'd0);
        reset = 1'b0;
        sb.push_back('{2'b01, 32'h0, 1});
        @(posedge clk); #1;
        chk("t4_reissue_wr", 64'(Mem_wr), 64'd1);
        chk("t4_reissue_wdata", 64'(Mem_wdata), 64'hA5A50001);
        chk("t4_reissue_addr", 64'(Mem_addr), 64'h44);
        wait_done("t4", cyc);
        check_pop("t4", cyc);
        D_req = 1'b0; D_wr = 1'b0;
        idle_gap("t4");
        chk("t4_sb_drained", 64'(sb.size()), 64'd0);

        // T5: READ_LATENCY=1 with I_req held -> done every 3 cycles, one idle cycle between
        u1_mem_rdata = 32'h0BADF00D; u1_I_addr = 32'hC; u1_I_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!u1_I_done && n < 20);
        chk("t5_first_done", 64'(u1_I_done), 64'd1);
        chk("t5_first_latency", 64'(n), 64'd2);
        busy_pat = '{1'b0, 1'b1, 1'b1};
        done_pat = '{1'b0, 1'b0, 1'b1};
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                chk("t5_busy", 64'(u1_Busy), 64'(busy_pat[k]));
                chk("t5_i_done", 64'(u1_I_done), 64'(done_pat[k]));
            end
        end
        chk("t5_i_rdata", 64'(u1_I_rdata), 64'h0BADF00D);
        u1_I_req = 1'b0;
        @(posedge clk); #1;

        // WRITE_LATENCY=3: strobe held exactly three cycles
        u1_D_wr = 1'b1; u1_D_addr = 32'h60; u1_D_wdata = 32'h0F0F0F0F; u1_D_req = 1'b1;
        wr_cycles = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (u1_Mem_wr) wr_cycles++;
        end while (!u1_D_done && n < 20);
        chk("t5w_done_seen", 64'(u1_D_done), 64'd1);
        chk("t5w_wr_cycles", 64'(wr_cycles), 64'd3);
        chk("t5w_mem_wdata", 64'(u1_Mem_wdata), 64'h0F0F0F0F);
        chk("t5w_d_rdata", 64'(u1_D_rdata), 64'd0);
        u1_D_req = 1'b0; u1_D_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
